// File: rtl/hamming_enc_sequencer.sv
// Memory-port master that walks N_MSG 11-bit messages, encodes each
// into a (16,11) SECDED Hamming word and writes the word back.
module hamming_enc_sequencer #(
  parameter int N_MSG    = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data,
  input  logic [7:0]        mem_rd_data
);

  localparam int IDX_W = (N_MSG > 1) ? $clog2(N_MSG) : 1;

  localparam logic [ADDR_W-1:0] SRC_A = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_A = ADDR_W'(DST_BASE);
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(N_MSG - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    CAP,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [7:0]       lo_byte;
  logic [7:0]       w_hi;
  logic [15:0]      w;
  logic             unused_hi;

  // Byte address of slot i (hi selects the upper byte), wrapping in ADDR_W bits.
  function automatic logic [ADDR_W-1:0] slot(
    input logic [ADDR_W-1:0] base,
    input logic [IDX_W-1:0]  i,
    input logic              hi
  );
    logic [ADDR_W-1:0] off;
    off = ADDR_W'({i, hi});
    return base + off;
  endfunction

  // (16,11) SECDED encoder; dv[0] is d1, dv[10] is d11.
  function automatic logic [15:0] enc(input logic [10:0] dv);
    logic [11:1] d;
    logic p8, p4, p2, p1, p0;
    d  = dv;
    p8 = ^d[11:5];
    p4 = ^d[11:8] ^ (^d[4:2]);
    p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    p0 = ^d[11:1] ^ p8 ^ p4 ^ p2 ^ p1;
    return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
  endfunction

  assign idx_nxt   = idx + IDX_W'(1);
  assign unused_hi = ^mem_rd_data[7:3];

  // Encode the captured low byte with the hi bits arriving this cycle.
  always_comb begin
    w = enc({mem_rd_data[2:0], lo_byte});
  end

  // Sequencer FSM: one state per cycle, all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= '0;
      lo_byte     <= '0;
      w_hi        <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RD_LO;
            idx      <= '0;
            done     <= 1'b0;
            busy     <= 1'b1;
            mem_addr <= slot(SRC_A, '0, 1'b0);
          end
        end
        RD_LO: begin
          state    <= RD_HI;
          mem_addr <= slot(SRC_A, idx, 1'b1);
        end
        RD_HI: begin
          state   <= CAP;
          lo_byte <= mem_rd_data;
        end
        CAP: begin
          state       <= WR_LO;
          w_hi        <= w[15:8];
          mem_addr    <= slot(DST_A, idx, 1'b0);
          mem_wr_en   <= 1'b1;
          mem_wr_data <= w[7:0];
        end
        WR_LO: begin
          state       <= WR_HI;
          mem_addr    <= slot(DST_A, idx, 1'b1);
          mem_wr_data <= w_hi;
        end
        WR_HI: begin
          mem_wr_en   <= 1'b0;
          mem_wr_data <= '0;
          if (idx == LAST) begin
            state    <= DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            mem_addr <= '0;
          end else begin
            state    <= RD_LO;
            idx      <= idx_nxt;
            mem_addr <= slot(SRC_A, idx_nxt, 1'b0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
